// File: rtl/isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : isa_pkg
// Purpose  : Shared ISA-level types plus the branch target buffer entry
//            layout and direction-counter constants used by the predictor.
// Contents : word_t, btb_entry_t, TAG_W_MAX, CTR_WEAK_TAKEN, CTR_RESET
// Revision : 1.0  initial release
// ============================================================================
package isa_pkg;

  typedef logic [31:0] word_t;

  // The smallest legal table (2 entries) leaves 29 tag bits. Entries always
  // carry this many tag bits; narrower tags are zero-extended so every bit
  // takes part in the compare.
  localparam int TAG_W_MAX = 29;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    word_t                target;
    logic [1:0]           ctr;
  } btb_entry_t;

  localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;
  localparam logic [1:0] CTR_RESET      = 2'b01;

endpackage
`default_nettype wire

// File: rtl/branch_predictor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : bp_sat_counter
// Purpose  : 2-bit saturating up/down counter step (00..11).
// Ports    : ctr      in  2  current counter value
//            up       in  1  1 = count up, 0 = count down
//            ctr_next out 2  saturated next value
// Revision : 1.0  initial release
// ============================================================================
module bp_sat_counter (
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (up) begin
      if (ctr != 2'b11) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) ctr_next = ctr - 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Next-PC predictor in front of fetch. Direct-mapped BTB with
//            2-bit direction counters, trained by a single update port from
//            execute, plus saturating branch / mispredict counters.
// Ports    : CLK, nRST (async, active-low)
//            pc                -> pc_prediction, predict_taken (combinational)
//            update_valid/pc/taken/target/mispredict  training port
//            branch_count, mispredict_count           performance counters
// Revision : 1.0  initial release
// ============================================================================
module branch_predictor
  import isa_pkg::*;
#(
  parameter int NENTRIES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc,
  output logic [31:0] pc_prediction,
  output logic        predict_taken,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        update_mispredict,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int IDX_W = $clog2(NENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  btb_entry_t btb_q [NENTRIES];
  btb_entry_t btb_d [NENTRIES];

  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  // Lookup path (reads only registered state, so no same-cycle bypass)
  logic [IDX_W-1:0]     lk_idx;
  logic [TAG_W_MAX-1:0] lk_tag;
  btb_entry_t           lk_entry;
  logic                 lk_hit;

  assign lk_idx   = pc[IDX_W+1:2];
  assign lk_tag   = TAG_W_MAX'(pc[31:IDX_W+2]);
  assign lk_entry = btb_q[lk_idx];
  assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);

  assign predict_taken = lk_hit && lk_entry.ctr[1];
  assign pc_prediction = predict_taken ? lk_entry.target : (pc + 32'd4);

  // Update path
  logic [IDX_W-1:0]     up_idx;
  logic [TAG_W_MAX-1:0] up_tag;
  btb_entry_t           up_entry;
  logic                 up_hit;
  logic [1:0]           up_ctr_next;

  assign up_idx   = update_pc[IDX_W+1:2];
  assign up_tag   = TAG_W_MAX'(update_pc[31:IDX_W+2]);
  assign up_entry = btb_q[up_idx];
  assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

  bp_sat_counter u_sat_counter (
    .ctr      (up_entry.ctr),
    .up       (update_taken),
    .ctr_next (up_ctr_next)
  );

  // Byte-offset bits of word-aligned PCs carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pc[1:0], update_pc[1:0]};

  always_comb begin
    btb_d = btb_q;
    if (update_valid) begin
      if (up_hit) begin
        btb_d[up_idx].ctr = up_ctr_next;
        if (update_taken) btb_d[up_idx].target = update_target;
      end else if (update_taken) begin
        // Allocation evicts whatever occupied the slot.
        btb_d[up_idx].valid  = 1'b1;
        btb_d[up_idx].tag    = up_tag;
        btb_d[up_idx].target = update_target;
        btb_d[up_idx].ctr    = CTR_WEAK_TAKEN;
      end
    end
  end

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (update_valid && (branch_count_q != 32'hFFFF_FFFF))
      branch_count_d = branch_count_q + 32'd1;
    if (update_valid && update_mispredict && (mispredict_count_q != 32'hFFFF_FFFF))
      mispredict_count_d = mispredict_count_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NENTRIES; i++) begin
        btb_q[i].valid  <= 1'b0;
        btb_q[i].tag    <= '0;
        btb_q[i].target <= '0;
        btb_q[i].ctr    <= CTR_RESET;
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      btb_q              <= btb_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Self-checking bench for branch_predictor (NENTRIES = 16).
//            Directed scenarios plus a randomized run against a table model.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_predictor;

  logic        CLK;
  logic        nRST;
  logic [31:0] pc;
  logic [31:0] pc_prediction;
  logic        predict_taken;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int n_tests = 0;
  int n_fail  = 0;

  branch_predictor #(.NENTRIES(16)) dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .pc                (pc),
    .pc_prediction     (pc_prediction),
    .predict_taken     (predict_taken),
    .update_valid      (update_valid),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_mispredict (update_mispredict),
    .branch_count      (branch_count),
    .mispredict_count  (mispredict_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  bit          m_valid [16];
  int unsigned m_tag   [16];
  bit [31:0]   m_tgt   [16];
  int          m_ctr   [16];
  longint      m_bc;
  longint      m_mc;
  localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

  function automatic int m_index(input bit [31:0] a);
    return int'((a / 4) % 16);
  endfunction

  function automatic int unsigned m_tagof(input bit [31:0] a);
    return a / 64;
  endfunction

  function automatic bit m_taken(input bit [31:0] a);
    int i = m_index(a);
    return m_valid[i] && (m_tag[i] == m_tagof(a)) && (m_ctr[i] >= 2);
  endfunction

  function automatic bit [31:0] m_pred(input bit [31:0] a);
    if (m_taken(a)) return m_tgt[m_index(a)];
    return a + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic m_update(input bit [31:0] a, input bit tk, input bit [31:0] tg, input bit mis);
    int i = m_index(a);
    if (m_bc < CNT_MAX) m_bc++;
    if (mis && m_mc < CNT_MAX) m_mc++;
    if (m_valid[i] && m_tag[i] == m_tagof(a)) begin
      if (tk) begin
        if (m_ctr[i] < 3) m_ctr[i]++;
        m_tgt[i] = tg;
      end else if (m_ctr[i] > 0) begin
        m_ctr[i]--;
      end
    end else if (tk) begin
      m_valid[i] = 1; m_tag[i] = m_tagof(a); m_tgt[i] = tg; m_ctr[i] = 2;
    end
  endtask

  // ---------------- drivers ----------------
  // Called away from the rising edge; returns 1 ns after the edge with
  // update_valid already dropped.
  task automatic do_update(input bit [31:0] a, input bit tk, input bit [31:0] tg, input bit mis);
    update_valid      = 1'b1;
    update_pc         = a;
    update_taken      = tk;
    update_target     = tg;
    update_mispredict = mis;
    @(posedge CLK);
    m_update(a, tk, tg, mis);
    #1;
    update_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
    m_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    pc = 32'h100;
    #1;
    n_tests++;
    if (pc_prediction !== 32'h104 || predict_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_lookup: got pred=%h taken=%b, expected 00000104 0", pc_prediction, predict_taken);
    end
    n_tests++;
    if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counts: got %0d/%0d, expected 0/0", branch_count, mispredict_count);
    end
    @(negedge CLK);
    nRST = 1'b1;
    m_reset();
    #1;
    n_tests++;
    if (pc_prediction !== 32'h104 || predict_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after: got pred=%h taken=%b, expected 00000104 0", pc_prediction, predict_taken);
    end
  endtask

  task automatic test_allocate();
    do_reset();
    @(negedge CLK);
    do_update(32'h100, 1'b1, 32'h400, 1'b1);
    @(negedge CLK);
    pc = 32'h100;
    #1;
    n_tests++;
    if (pc_prediction !== 32'h400 || predict_taken !== 1'b1 || branch_count !== 32'd1) begin
      n_fail++;
      $display("FAIL allocate: got pred=%h taken=%b bc=%0d, expected 00000400 1 1",
               pc_prediction, predict_taken, branch_count);
    end
    n_tests++;
    if (mispredict_count !== 32'd1) begin
      n_fail++;
      $display("FAIL allocate_mc: got %0d, expected 1", mispredict_count);
    end
  endtask

  task automatic test_hysteresis();
    bit        tk_seq  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit [31:0] exp_pred[4] = '{32'h104, 32'h400, 32'h400, 32'h400};
    do_reset();
    @(negedge CLK);
    do_update(32'h100, 1'b1, 32'h400, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      do_update(32'h100, tk_seq[k], 32'h400, 1'b0);
      @(negedge CLK);
      pc = 32'h100;
      #1;
      n_tests++;
      if (pc_prediction !== exp_pred[k]) begin
        n_fail++;
        $display("FAIL hysteresis_%0d: got %h, expected %h", k, pc_prediction, exp_pred[k]);
      end
    end
  endtask

  task automatic test_aliasing();
    do_reset();
    @(negedge CLK);
    do_update(32'h100, 1'b1, 32'h400, 1'b0);
    @(negedge CLK);
    do_update(32'h500, 1'b1, 32'h900, 1'b0);
    @(negedge CLK);
    pc = 32'h100;
    #1;
    n_tests++;
    if (pc_prediction !== 32'h104 || predict_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL alias_old: got pred=%h taken=%b, expected 00000104 0", pc_prediction, predict_taken);
    end
    pc = 32'h500;
    #1;
    n_tests++;
    if (pc_prediction !== 32'h900 || predict_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL alias_new: got pred=%h taken=%b, expected 00000900 1", pc_prediction, predict_taken);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    @(negedge CLK);
    pc                = 32'h100;
    update_valid      = 1'b1;
    update_pc         = 32'h100;
    update_taken      = 1'b1;
    update_target     = 32'h800;
    update_mispredict = 1'b0;
    #1;
    n_tests++;
    if (pc_prediction !== 32'h104) begin
      n_fail++;
      $display("FAIL same_cycle_old: got %h, expected 00000104", pc_prediction);
    end
    @(posedge CLK);
    m_update(32'h100, 1'b1, 32'h800, 1'b0);
    #1;
    update_valid = 1'b0;
    n_tests++;
    if (pc_prediction !== 32'h800) begin
      n_fail++;
      $display("FAIL same_cycle_new: got %h, expected 00000800", pc_prediction);
    end
    // 0x140 shares index 0 with 0x100 but has a different tag
    @(negedge CLK);
    do_update(32'h140, 1'b0, 32'hDEAD_BEE0, 1'b0);
    @(negedge CLK);
    pc = 32'h100;
    #1;
    n_tests++;
    if (pc_prediction !== 32'h800 || predict_taken !== 1'b1) begin
      n_fail++;
      $display("FAIL nt_miss_untouched: got pred=%h taken=%b, expected 00000800 1", pc_prediction, predict_taken);
    end
    pc = 32'h140;
    #1;
    n_tests++;
    if (pc_prediction !== 32'h144) begin
      n_fail++;
      $display("FAIL nt_miss_noalloc: got %h, expected 00000144", pc_prediction);
    end
  endtask

  task automatic test_random();
    bit [31:0] a, ua, tg;
    bit        uv, tk, mis;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      a   = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      ua  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC;
      tg  = $urandom & 32'hFFFF_FFFC;
      uv  = ($urandom_range(0, 1) == 1);
      tk  = ($urandom_range(0, 2) != 0);
      mis = ($urandom_range(0, 3) == 0);
      pc                = a;
      update_valid      = uv;
      update_pc         = ua;
      update_taken      = tk;
      update_target     = tg;
      update_mispredict = mis;
      #1;
      n_tests++;
      if (pc_prediction !== m_pred(a) || predict_taken !== m_taken(a)) begin
        n_fail++;
        $display("FAIL random_lookup[%0d] pc=%h: got pred=%h taken=%b, expected %h %b",
                 k, a, pc_prediction, predict_taken, m_pred(a), m_taken(a));
      end
      n_tests++;
      if (branch_count !== m_bc[31:0] || mispredict_count !== m_mc[31:0]) begin
        n_fail++;
        $display("FAIL random_counts[%0d]: got %0d/%0d, expected %0d/%0d",
                 k, branch_count, mispredict_count, m_bc, m_mc);
      end
      @(posedge CLK);
      if (uv) m_update(ua, tk, tg, mis);
      #1;
      update_valid = 1'b0;
    end
  endtask

  task automatic test_saturation();
    bit [31:0] exp_mc [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    do_reset();
    @(negedge CLK);
    force dut.mispredict_count_q = 32'hFFFF_FFFD;
    #1;
    release dut.mispredict_count_q;
    m_mc = 64'hFFFF_FFFD;
    #1;
    n_tests++;
    if (mispredict_count !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("FAIL sat_preload: got %h, expected fffffffd", mispredict_count);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      do_update(32'h200, 1'b0, 32'h0, 1'b1);
      @(negedge CLK);
      n_tests++;
      if (mispredict_count !== exp_mc[k]) begin
        n_fail++;
        $display("FAIL sat_mc_%0d: got %h, expected %h", k, mispredict_count, exp_mc[k]);
      end
    end
    n_tests++;
    if (branch_count !== 32'd3) begin
      n_fail++;
      $display("FAIL sat_bc: got %0d, expected 3", branch_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge CLK);
    do_update(32'h100, 1'b1, 32'h400, 1'b1);
    @(negedge CLK);
    pc                = 32'h100;
    update_valid      = 1'b1;
    update_pc         = 32'h100;
    update_taken      = 1'b1;
    update_target     = 32'h600;
    update_mispredict = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    n_tests++;
    if (pc_prediction !== 32'h104 || predict_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_lookup: got pred=%h taken=%b, expected 00000104 0", pc_prediction, predict_taken);
    end
    n_tests++;
    if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset_counts: got %0d/%0d, expected 0/0", branch_count, mispredict_count);
    end
    @(posedge CLK);
    #1;
    update_valid = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    m_reset();
    #1;
    n_tests++;
    if (pc_prediction !== 32'h104 || branch_count !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset_held: got pred=%h bc=%0d, expected 00000104 0", pc_prediction, branch_count);
    end
  endtask

  initial begin
    nRST              = 1'b0;
    pc                = 32'h0;
    update_valid      = 1'b0;
    update_pc         = 32'h0;
    update_taken      = 1'b0;
    update_target     = 32'h0;
    update_mispredict = 1'b0;
    m_reset();
    test_reset();
    test_allocate();
    test_hysteresis();
    test_aliasing();
    test_same_cycle();
    test_random();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
